// File: rtl/i2s_pkg.sv
// Shared types and sizing constants for the I2S stereo receiver.
package i2s_pkg;

  localparam int unsigned I2S_MAX_SLOT = 64;
  localparam int unsigned I2S_BITCNT_W = $clog2(I2S_MAX_SLOT + 2);

  typedef enum logic [1:0] {
    IDLE,
    LEFT,
    RIGHT
  } i2s_rx_state_e;

endpackage

// File: rtl/i2s_sync_edge.sv
// Synchronises bclk/lrclk/sdata into clk and strobes on each bclk rising edge,
// with lrclk/sdata delayed to line up with the strobe.
module i2s_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_bclk,
  input  logic i_lrclk,
  input  logic i_sdata,
  output logic o_bclk_rise,
  output logic o_lrclk,
  output logic o_sdata
);

  logic [SYNC_STAGES-1:0] r_bclk_sync;
  logic [SYNC_STAGES-1:0] r_lrclk_sync;
  logic [SYNC_STAGES-1:0] r_sdata_sync;
  logic                   r_bclk_prev;
  logic                   r_rise;
  logic                   r_lrclk;
  logic                   r_sdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bclk_sync  <= '0;
      r_lrclk_sync <= '0;
      r_sdata_sync <= '0;
      r_bclk_prev  <= 1'b0;
      r_rise       <= 1'b0;
      r_lrclk      <= 1'b0;
      r_sdata      <= 1'b0;
    end else begin
      r_bclk_sync  <= {r_bclk_sync[SYNC_STAGES-2:0], i_bclk};
      r_lrclk_sync <= {r_lrclk_sync[SYNC_STAGES-2:0], i_lrclk};
      r_sdata_sync <= {r_sdata_sync[SYNC_STAGES-2:0], i_sdata};
      r_bclk_prev  <= r_bclk_sync[SYNC_STAGES-1];
      r_rise       <= r_bclk_sync[SYNC_STAGES-1] & ~r_bclk_prev;
      r_lrclk      <= r_lrclk_sync[SYNC_STAGES-1];
      r_sdata      <= r_sdata_sync[SYNC_STAGES-1];
    end
  end

  assign o_bclk_rise = r_rise;
  assign o_lrclk     = r_lrclk;
  assign o_sdata     = r_sdata;

endmodule

// File: rtl/i2s_rx_stereo.sv
// I2S stereo receiver: deserialises left/right slots and presents one pair per frame
// on valid/ready. Define I2S_RX_LJ_MODE_EN to add the lj_mode (left-justified) input.
module i2s_rx_stereo
  import i2s_pkg::*;
#(
  parameter int unsigned DATA_W      = 24,
  parameter int unsigned SLOT_W      = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
`ifdef I2S_RX_LJ_MODE_EN
  input  logic              lj_mode,
`endif
  input  logic              bclk,
  input  logic              lrclk,
  input  logic              sdata,
  output logic [DATA_W-1:0] out_left,
  output logic [DATA_W-1:0] out_right,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun,
  output logic              frame_err
);

  localparam int unsigned CNT_W = I2S_BITCNT_W;
  localparam logic [CNT_W-1:0] CNT_DATA = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_SLOT = CNT_W'(SLOT_W);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SLOT_W + 1);

  // Short slots are MSB-aligned with zero LSBs.
  function automatic logic [DATA_W-1:0] f_align(input logic [DATA_W-1:0] sh,
                                                input logic [CNT_W-1:0]  cnt);
    logic [DATA_W-1:0] res;
    if (cnt >= CNT_DATA) res = sh;
    else                 res = sh << (CNT_DATA - cnt);
    return res;
  endfunction

  logic              w_rise, w_lr, w_sd, w_lj_in;
  logic              w_boundary, w_long, w_short, w_pair;
  logic [CNT_W-1:0]  w_cnt_inc, w_close_cnt, w_start_cnt;
  logic [DATA_W-1:0] w_shift_in, w_close_shift, w_close_word, w_start_shift;

  i2s_rx_state_e     r_state, w_state_nxt;
  logic              r_lr_prev, r_lj, w_lj_nxt;
  logic [DATA_W-1:0] r_shift, w_shift_nxt, r_left_word, w_left_nxt;
  logic [CNT_W-1:0]  r_bit_cnt, w_cnt_nxt;
  logic [DATA_W-1:0] r_out_left, r_out_right, w_out_left_nxt, w_out_right_nxt;
  logic              r_out_valid, w_out_valid_nxt;
  logic              r_overrun, w_overrun_nxt, r_frame_err, w_frame_err_nxt;

`ifdef I2S_RX_LJ_MODE_EN
  assign w_lj_in = lj_mode;
`else
  assign w_lj_in = 1'b0;
`endif

  i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk        (clk),
    .reset      (reset),
    .i_bclk     (bclk),
    .i_lrclk    (lrclk),
    .i_sdata    (sdata),
    .o_bclk_rise(w_rise),
    .o_lrclk    (w_lr),
    .o_sdata    (w_sd)
  );

  assign w_boundary = w_rise & (w_lr != r_lr_prev);
  assign w_cnt_inc  = (r_bit_cnt == CNT_MAX) ? r_bit_cnt : r_bit_cnt + CNT_W'(1);
  assign w_shift_in = (r_bit_cnt < CNT_DATA) ? {r_shift[DATA_W-2:0], w_sd} : r_shift;
  assign w_long     = (r_bit_cnt == CNT_SLOT);

  // In I2S mode D_n still belongs to the closing slot; in LJ mode it opens the next one.
  assign w_close_shift = r_lj ? r_shift : w_shift_in;
  assign w_close_cnt   = r_lj ? r_bit_cnt : w_cnt_inc;
  assign w_close_word  = f_align(w_close_shift, w_close_cnt);
  assign w_short       = (w_close_cnt < CNT_DATA);
  assign w_start_shift = r_lj ? DATA_W'(w_sd) : '0;
  assign w_start_cnt   = r_lj ? CNT_W'(1) : '0;

  always_comb begin
    w_state_nxt     = r_state;
    w_shift_nxt     = r_shift;
    w_cnt_nxt       = r_bit_cnt;
    w_left_nxt      = r_left_word;
    w_lj_nxt        = r_lj;
    w_pair          = 1'b0;
    w_frame_err_nxt = 1'b0;
    w_out_left_nxt  = r_out_left;
    w_out_right_nxt = r_out_right;
    w_out_valid_nxt = r_out_valid;
    w_overrun_nxt   = 1'b0;

    if (r_state == IDLE) w_lj_nxt = w_lj_in;

    if (!enable) begin
      w_state_nxt = IDLE;
      w_shift_nxt = '0;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_boundary && !w_lr) begin
            w_state_nxt = LEFT;
            w_shift_nxt = w_start_shift;
            w_cnt_nxt   = w_start_cnt;
          end
        end
        LEFT, RIGHT: begin
          if (w_boundary) begin
            w_frame_err_nxt = w_short | (w_long & ~r_lj);
            w_shift_nxt     = w_start_shift;
            w_cnt_nxt       = w_start_cnt;
            if (r_state == LEFT) begin
              w_state_nxt = RIGHT;
              w_left_nxt  = w_close_word;
            end else begin
              w_state_nxt = LEFT;
              w_pair      = 1'b1;
            end
          end else if (w_rise) begin
            w_shift_nxt     = w_shift_in;
            w_cnt_nxt       = w_cnt_inc;
            w_frame_err_nxt = w_long;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end

    // Output handshake: a new pair always wins; an unaccepted pending pair is an overrun.
    if (w_pair) begin
      w_out_left_nxt  = r_left_word;
      w_out_right_nxt = w_close_word;
      w_out_valid_nxt = 1'b1;
      w_overrun_nxt   = r_out_valid & ~out_ready;
    end else if (r_out_valid && out_ready) begin
      w_out_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_lr_prev   <= 1'b0;
      r_lj        <= 1'b0;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_left_word <= '0;
      r_out_left  <= '0;
      r_out_right <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      if (w_rise) r_lr_prev <= w_lr;
      r_lj        <= w_lj_nxt;
      r_shift     <= w_shift_nxt;
      r_bit_cnt   <= w_cnt_nxt;
      r_left_word <= w_left_nxt;
      r_out_left  <= w_out_left_nxt;
      r_out_right <= w_out_right_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_overrun   <= w_overrun_nxt;
      r_frame_err <= w_frame_err_nxt;
    end
  end

  assign out_left  = r_out_left;
  assign out_right = r_out_right;
  assign out_valid = r_out_valid;
  assign overrun   = r_overrun;
  assign frame_err = r_frame_err;

endmodule
